// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared FSM encoding and round-robin pick function for the uart_tx arbiter
package uart_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // rr_pick works on a request vector padded to this width; NUM_REQ must not exceed it.
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = $clog2(RR_MAX_REQ);

    // First set bit of req searching upward from ptr+1, wrapping modulo n.
    function automatic int rr_pick(input logic [RR_MAX_REQ-1:0] req, input int ptr, input int n);
        int   cand;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            cand = (ptr + k) % n;
            if (k <= n && !found && req[cand[RR_IDX_W-1:0]]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester byte streams and uart_tx handshake bundled for the arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_valid;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_ready;

    modport master (
        output req_valid, req_last, req_data, tx_ready,
        input  req_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_last, req_data, tx_ready,
        output req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin winner selection starting after ptr
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    logic [RR_MAX_REQ-1:0] req_pad;

    always_comb begin
        req_pad              = '0;
        req_pad[NUM_REQ-1:0] = req;
        any                  = |req;
        idx                  = ID_W'(rr_pick(req_pad, int'(ptr), NUM_REQ));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-locked sharing of one uart_tx among NUM_REQ requesters
// Optional idle-lock release is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_WIDTH     = 8,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  arb,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy,
    output logic              timeout_evt
);

    localparam logic [0:0] S_IDLE = ARB_IDLE;
    localparam logic [0:0] S_LOCK = ARB_LOCK;

    logic [0:0]      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            pick_any;
    logic [ID_W-1:0] pick_idx;
    logic            g_valid, g_last, xfer;
    logic            release_timeout;

    uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req (arb.req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Only the owner is routed to uart_tx; everybody else sees ready low while locked.
    always_comb begin
        g_valid       = arb.req_valid[grant_q];
        g_last        = arb.req_last[grant_q];
        xfer          = (state_q == S_LOCK) && g_valid && arb.tx_ready;
        arb.tx_valid  = (state_q == S_LOCK) && g_valid;
        arb.tx_data   = arb.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        arb.req_ready = '0;
        if (state_q == S_LOCK) begin
            arb.req_ready[grant_q] = arb.tx_ready;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             to_evt_q, to_evt_d;

    // Holding the counter at zero while idle covers the clear-on-entry case.
    always_comb begin
        release_timeout = (state_q == S_LOCK) && !xfer
                          && (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        if (state_q == S_IDLE || xfer) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        to_evt_d = release_timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
            to_evt_q   <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            to_evt_q   <= to_evt_d;
        end
    end

    assign timeout_evt = to_evt_q;
`else
    assign release_timeout = 1'b0;
    assign timeout_evt     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if ((xfer && g_last) || release_timeout) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = grant_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == S_LOCK);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and random checks of uart_tx_arbiter against a message-level model
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int TO   = 64;
    localparam int ID_W = 2;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int EXP_TO = 1;
    localparam int STALL  = 40;
`else
    localparam int EXP_TO = 0;
    localparam int STALL  = 100;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ID_W-1:0] grant_id;
    logic            busy;
    logic            timeout_evt;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .arb         (bus.slave),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] dq [N][$];
    bit            lq [N][$];
    bit            en [N];
    int            gap     = 0;
    int            gap_max = 4;
    int            log_src [$];
    logic [DW-1:0] log_dat [$];
    int            r0_seen = 0;
    int            to_seen = 0;
    int            pushed  = 0;

    // Message-level reference: who owns the line, who finished last, idle cycles in lock.
    bit m_busy;
    bit m_to;
    int m_owner;
    int m_last;
    int m_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += dq[i].size();
        return s;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_to    = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_idle  = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = en[i] && (dq[i].size() > 0);
            bus.req_last[i]          = (dq[i].size() > 0) ? lq[i][0] : 1'b0;
            bus.req_data[i*DW +: DW] = (dq[i].size() > 0) ? dq[i][0] : '0;
        end
        bus.tx_ready = (gap == 0);
    endtask

    task automatic push_msg(input int r, input int len, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++) begin
            dq[r].push_back(base + DW'(k));
            lq[r].push_back(k == len - 1);
        end
        pushed += len;
        drive();
    endtask

    task automatic clear_log();
        log_src.delete();
        log_dat.delete();
    endtask

    task automatic cycle();
        logic [N-1:0] v;
        logic [N-1:0] rdy_exp;
        logic         tr;
        @(negedge clk);
        v  = bus.req_valid;
        tr = bus.tx_ready;
        chk("busy", busy, m_busy);
        chk("timeout_evt", timeout_evt, m_to);
        chk("grant_id", grant_id, m_owner);
        if (m_busy) begin
            rdy_exp          = '0;
            rdy_exp[m_owner] = tr;
            chk("tx_valid", bus.tx_valid, v[m_owner]);
            chk("req_ready", bus.req_ready, rdy_exp);
            if (v[m_owner]) chk("tx_data", bus.tx_data, dq[m_owner][0]);
        end else begin
            chk("idle_tx_valid", bus.tx_valid, 0);
            chk("idle_req_ready", bus.req_ready, 0);
        end
        if (bus.req_ready[0] === 1'b1) r0_seen++;
        if (timeout_evt === 1'b1) to_seen++;

        m_to = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            if (v[m_owner] && tr) begin
                m_idle = 0;
                if (lq[m_owner][0]) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end else begin
                m_idle++;
`ifdef UART_ARB_TIMEOUT_EN
                if (m_idle == TO) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                    m_to   = 1'b1;
                end
`endif
            end
        end else if (v != '0) begin
            m_owner = rr_next(m_last, v);
            m_busy  = 1'b1;
            m_idle  = 0;
        end

        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i] === 1'b1) begin
                    log_src.push_back(i);
                    log_dat.push_back(dq[i][0]);
                    void'(dq[i].pop_front());
                    void'(lq[i].pop_front());
                end
            end
            if (bus.tx_valid === 1'b1 && tr) gap = $urandom_range(gap_max, 1);
            else if (gap > 0) gap--;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (k < bound && (pending() > 0 || m_busy)) begin
            cycle();
            k++;
        end
        chk("drain_left", pending() + int'(busy), 0);
    endtask

    task automatic wait_log(input int n, input int bound);
        int k = 0;
        while (k < bound && log_src.size() < n) begin
            cycle();
            k++;
        end
        chk("log_fill", log_src.size() >= n, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        model_reset();
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        cycle();

        // single requester "AB"
        clear_log();
        push_msg(0, 2, 8'h41);
        wait_idle(200);
        chk("t1_len", log_src.size(), 2);
        for (int k = 0; k < log_src.size(); k++) begin
            chk("t1_src", log_src[k], 0);
            chk("t1_dat", log_dat[k], 8'h41 + k);
        end
        chk("t1_grant", grant_id, 0);

        // four simultaneous two-byte messages after reset
        pulse_reset();
        clear_log();
        for (int i = 0; i < N; i++) push_msg(i, 2, DW'(8'h10 * (i + 1)));
        wait_idle(400);
        chk("t2_len", log_src.size(), 2 * N);
        for (int k = 0; k < log_src.size(); k++) begin
            chk("t2_src", log_src[k], k / 2);
            chk("t2_dat", log_dat[k], 8'h10 * (k / 2 + 1) + (k % 2));
        end

        // rotation between requesters 1 and 3
        clear_log();
        for (int j = 0; j < 6; j++) begin
            push_msg(1, 1, DW'(8'h20 + j));
            push_msg(3, 1, DW'(8'h30 + j));
        end
        wait_idle(600);
        chk("t3_len", log_src.size(), 12);
        for (int k = 0; k < log_src.size(); k++) chk("t3_src", log_src[k], (k % 2 == 0) ? 1 : 3);

        // owner stalls mid-message while another requester waits
        clear_log();
        push_msg(2, 3, 8'h80);
        wait_log(1, 200);
        en[2] = 1'b0;
        drive();
        push_msg(0, 1, 8'h90);
        r0_seen = 0;
        repeat (STALL) cycle();
        chk("t4_r0_ready", r0_seen, 0);
        chk("t4_busy", busy, 1);
        chk("t4_grant", grant_id, 2);
        en[2] = 1'b1;
        drive();
        wait_idle(400);
        chk("t4_len", log_src.size(), 4);
        for (int k = 0; k < log_src.size(); k++) chk("t4_src", log_src[k], (k < 3) ? 2 : 0);

        // reset while requester 1 is mid-message
        clear_log();
        push_msg(1, 3, 8'h50);
        wait_log(1, 200);
        push_msg(2, 1, 8'h58);
        push_msg(3, 1, 8'h59);
        pulse_reset();
        pushed -= dq[1].size();
        dq[1].delete();
        lq[1].delete();
        drive();
        clear_log();
        wait_idle(400);
        chk("t5_first", (log_src.size() > 0) ? log_src[0] : -1, 2);

        // random traffic with valid gaps and variable uart_tx frame time
        clear_log();
        pushed  = 0;
        gap_max = 8;
        repeat (2000) begin
            if ($urandom_range(3, 0) == 0) begin
                int r;
                r = $urandom_range(N - 1, 0);
                if (dq[r].size() < 8) push_msg(r, $urandom_range(4, 1), DW'($urandom));
            end
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(7, 0) != 0);
            drive();
            cycle();
        end
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        drive();
        wait_idle(3000);
        chk("rand_count", log_src.size(), pushed);

        // requester 3 dies before its last byte
        gap_max = 4;
        clear_log();
        push_msg(3, 3, 8'h60);
        wait_log(1, 200);
        en[3] = 1'b0;
        drive();
        push_msg(0, 1, 8'h70);
        to_seen = 0;
        repeat (80) cycle();
        chk("t6_pulses", to_seen, EXP_TO);
        en[3] = 1'b1;
        drive();
        wait_idle(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
